// File: rtl/relu_norm_writer_if.sv
// Pre-activation stream from the MAC unit plus the write/clear port of the
// layer activation buffer. The writer holds the master side.
interface relu_norm_writer_if #(
    parameter int NUM_NEURONS = 256,
    parameter int DATA_WIDTH  = 32
);
    localparam int AW = $clog2(NUM_NEURONS);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  buf_clear;
    logic                  buf_we;
    logic [AW-1:0]         buf_waddr;
    logic [DATA_WIDTH-1:0] buf_wdata;

    modport master (
        input  in_valid, in_data,
        output in_ready, buf_clear, buf_we, buf_waddr, buf_wdata
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, buf_clear, buf_we, buf_waddr, buf_wdata
    );
endinterface

// File: rtl/relu_norm_writer.sv
// ReLU + mean-normalise one layer of pre-activation sums, then write the
// normalised activations into the activation buffer one neuron per pulse.
module relu_norm_writer #(
    parameter int NUM_NEURONS = 256,
    parameter int DATA_WIDTH  = 32,
    parameter int FRAC_BITS   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    relu_norm_writer_if.master bus,
    output logic               busy,
    output logic               done
);
    localparam int AW = $clog2(NUM_NEURONS);
    localparam int SW = DATA_WIDTH + AW;
    localparam int QW = DATA_WIDTH + FRAC_BITS;
    localparam int CW = $clog2(QW);
    localparam logic [AW-1:0] LAST = AW'(NUM_NEURONS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_MEAN,
        S_DIVIDE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                state_q;
    logic [AW-1:0]         idx_q;
    logic [SW-1:0]         sum_q;
    logic [DATA_WIDTH-1:0] stage_q [NUM_NEURONS];
    logic [DATA_WIDTH-1:0] div_q;
    logic                  zero_q;
    logic [DATA_WIDTH-1:0] rem_q;
    logic [QW-1:0]         dvd_q;
    logic [CW-1:0]         cnt_q;
    logic                  in_ready_q;
    logic                  buf_clear_q;
    logic                  buf_we_q;
    logic [AW-1:0]         buf_waddr_q;
    logic [DATA_WIDTH-1:0] buf_wdata_q;
    logic                  busy_q;
    logic                  done_q;

    logic [DATA_WIDTH:0]   trial;
    logic                  qbit;
    logic [DATA_WIDTH-1:0] rem_d;
    logic [QW-1:0]         dvd_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic [DATA_WIDTH-1:0] relu_d;
    logic [DATA_WIDTH-1:0] mean_d;
    logic                  accept;

    // One restoring step: dvd_q shifts the dividend out of its top while the
    // quotient bits shift in at the bottom, so after QW steps it holds q.
    always_comb begin
        trial   = {rem_q, dvd_q[QW-1]};
        qbit    = (trial >= {1'b0, div_q});
        rem_d   = qbit ? DATA_WIDTH'(trial - {1'b0, div_q}) : trial[DATA_WIDTH-1:0];
        dvd_d   = {dvd_q[QW-2:0], qbit};
        wdata_d = '0;
        if (!zero_q) begin
            wdata_d = (|dvd_d[QW-1:DATA_WIDTH-1]) ? {1'b0, {(DATA_WIDTH-1){1'b1}}}
                                                   : dvd_d[DATA_WIDTH-1:0];
        end
        relu_d  = bus.in_data[DATA_WIDTH-1] ? '0 : bus.in_data;
        mean_d  = sum_q[SW-1:AW];
        accept  = in_ready_q && bus.in_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            sum_q       <= '0;
            for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
                stage_q[i] <= '0;
            end
            div_q       <= '0;
            zero_q      <= 1'b0;
            rem_q       <= '0;
            dvd_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            buf_clear_q <= 1'b0;
            buf_we_q    <= 1'b0;
            buf_waddr_q <= '0;
            buf_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            buf_clear_q <= 1'b0;
            buf_we_q    <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q     <= S_COLLECT;
                        buf_clear_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b1;
                        idx_q       <= '0;
                        sum_q       <= '0;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_COLLECT: begin
                    if (accept) begin
                        stage_q[idx_q] <= relu_d;
                        sum_q          <= sum_q + SW'(relu_d);
                        idx_q          <= idx_q + 1'b1;
                        if (idx_q == LAST) begin
                            state_q    <= S_MEAN;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                S_MEAN: begin
                    zero_q  <= (sum_q == '0);
                    div_q   <= (sum_q == '0) ? '0 :
                               (mean_d == '0) ? DATA_WIDTH'(1) : mean_d;
                    dvd_q   <= {stage_q[idx_q], {FRAC_BITS{1'b0}}};
                    rem_q   <= '0;
                    cnt_q   <= CW'(QW - 1);
                    state_q <= S_DIVIDE;
                end
                S_DIVIDE: begin
                    rem_q <= rem_d;
                    dvd_q <= dvd_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_q     <= S_WRITE;
                        buf_we_q    <= 1'b1;
                        buf_waddr_q <= idx_q;
                        buf_wdata_q <= wdata_d;
                    end
                end
                S_WRITE: begin
                    if (idx_q == LAST) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        idx_q   <= '0;
                    end else begin
                        state_q <= S_DIVIDE;
                        idx_q   <= idx_q + 1'b1;
                        dvd_q   <= {stage_q[idx_q + 1'b1], {FRAC_BITS{1'b0}}};
                        rem_q   <= '0;
                        cnt_q   <= CW'(QW - 1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.buf_clear = buf_clear_q;
    assign bus.buf_we    = buf_we_q;
    assign bus.buf_waddr = buf_waddr_q;
    assign bus.buf_wdata = buf_wdata_q;
    assign busy          = busy_q;
    assign done          = done_q;
endmodule

// File: tb/tb_relu_norm_writer.sv
// Bench for relu_norm_writer at NUM_NEURONS=4: timeline model of the layer pass,
// arithmetic reference for the normalised values, per-cycle output comparison.
module tb_relu_norm_writer;
    localparam int N    = 4;
    localparam int LOGN = 2;
    localparam int DW   = 32;
    localparam int FB   = 16;
    localparam int SLOT = DW + FB + 1;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic done;

    relu_norm_writer_if #(.NUM_NEURONS(N), .DATA_WIDTH(DW)) bus ();

    relu_norm_writer #(.NUM_NEURONS(N), .DATA_WIDTH(DW), .FRAC_BITS(FB)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Reference: phase of the pass plus the cycle (k) of the MEAN step;
    // every later event is placed by arithmetic on k.
    typedef enum int {P_IDLE, P_COL, P_PROC} phase_t;
    phase_t          ph      = P_IDLE;
    int              nb      = 0;
    bit              first   = 1'b0;
    int              k       = 0;
    int              cyc     = 0;
    logic [DW-1:0]   beats [N];
    logic [LOGN-1:0] lw_addr = '0;
    logic [DW-1:0]   lw_data = '0;

    int              checks  = 0;
    int              errors  = 0;
    int              clr_cnt = 0;
    int              tmo_cnt = 0;
    int              tmo_seen = 0;
    bit              pin_en  = 1'b0;
    logic [DW-1:0]   pin_lit [N];
    logic [DW-1:0]   cap [N];

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] x);
        return x[DW-1] ? '0 : x;
    endfunction

    function automatic logic [DW-1:0] model_q(input int i);
        longint unsigned s, m, q;
        s = 0;
        for (int j = 0; j < N; j++) s += 64'(relu(beats[j]));
        if (s == 0) return '0;
        m = (s >> LOGN) & 64'hFFFF_FFFF;
        if (m == 0) m = 1;
        q = (64'(relu(beats[i])) << FB) / m;
        if (q > 64'h7FFF_FFFF) q = 64'h7FFF_FFFF;
        return q[DW-1:0];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph      <= P_IDLE;
            nb      <= 0;
            first   <= 1'b0;
            lw_addr <= '0;
            lw_data <= '0;
        end else begin
            first <= 1'b0;
            case (ph)
                P_IDLE: if (start) begin
                    ph <= P_COL; nb <= 0; first <= 1'b1;
                end
                P_COL: if (bus.in_valid) begin
                    beats[nb] <= bus.in_data;
                    nb        <= nb + 1;
                    if (nb == N - 1) begin
                        ph <= P_PROC;
                        k  <= cyc + 1;
                    end
                end
                P_PROC: begin
                    if (cyc >= k + SLOT && cyc <= k + SLOT * N && (cyc - k) % SLOT == 0) begin
                        lw_addr <= LOGN'((cyc - k) / SLOT - 1);
                        lw_data <= model_q((cyc - k) / SLOT - 1);
                    end
                    if (cyc == k + 1 + SLOT * N) begin
                        if (start) begin
                            ph <= P_COL; nb <= 0; first <= 1'b1;
                        end else begin
                            ph <= P_IDLE;
                        end
                    end
                end
                default: ph <= P_IDLE;
            endcase
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: every output, every cycle, sampled on the falling edge.
    initial begin
        int  c;
        int  wi;
        bit  exp_we, exp_done, exp_busy;
        forever begin
            @(negedge clk);
            c = cyc;
            if (rst === 1'b1) begin
                chk("rst_in_ready", bus.in_ready, 0);
                chk("rst_buf_clear", bus.buf_clear, 0);
                chk("rst_buf_we", bus.buf_we, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_buf_waddr", bus.buf_waddr, 0);
                chk("rst_buf_wdata", bus.buf_wdata, 0);
                clr_cnt = 0;
            end else if (rst === 1'b0) begin
                exp_we   = (ph == P_PROC) && c >= k + SLOT && c <= k + SLOT * N && ((c - k) % SLOT == 0);
                exp_done = (ph == P_PROC) && c == k + 1 + SLOT * N;
                exp_busy = (ph == P_COL) || (ph == P_PROC && c <= k + SLOT * N);
                chk("in_ready", bus.in_ready, ph == P_COL);
                chk("buf_clear", bus.buf_clear, first);
                chk("busy", busy, exp_busy);
                chk("buf_we", bus.buf_we, exp_we);
                chk("done", done, exp_done);
                if (exp_we) begin
                    wi = (c - k) / SLOT - 1;
                    chk("write_addr", bus.buf_waddr, wi);
                    chk("write_data", bus.buf_wdata, model_q(wi));
                end else begin
                    chk("hold_addr", bus.buf_waddr, lw_addr);
                    chk("hold_data", bus.buf_wdata, lw_data);
                end
                if (bus.buf_clear === 1'b1) clr_cnt++;
                if (bus.buf_we === 1'b1 && !$isunknown(bus.buf_waddr)) cap[bus.buf_waddr] = bus.buf_wdata;
                if (done === 1'b1 && pin_en) chk("latency_beat_to_done", c - k + 1, 2 + N * SLOT);
                if (exp_done) begin
                    chk("clears_per_layer", clr_cnt, 1);
                    clr_cnt = 0;
                    if (pin_en) begin
                        for (int i = 0; i < N; i++) begin
                            chk("model_vs_literal", model_q(i), pin_lit[i]);
                            chk("dut_vs_literal", cap[i], pin_lit[i]);
                        end
                    end
                end
                if (tmo_cnt != tmo_seen) begin
                    chk("done_within_bound", done, 1);
                    tmo_seen = tmo_cnt;
                end
            end
        end
    end

    task automatic run_layer(input logic [DW-1:0] v [N], input int stall,
                             input bit hold, input bit chain, input bit skip_start);
        bit got;
        if (skip_start) begin
            start = hold;
        end else begin
            start = 1'b1;
            @(posedge clk); #1;
            start = hold;
        end
        for (int i = 0; i < N; i++) begin
            while (int'($urandom_range(0, 99)) < stall) begin
                bus.in_valid = 1'b0;
                bus.in_data  = $urandom;
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = v[i];
            @(posedge clk); #1;
        end
        got = 1'b0;
        for (int t = 0; t < 400 && !got; t++) begin
            if (done === 1'b1) begin
                got = 1'b1;
            end else begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_data  = $urandom;
                @(posedge clk); #1;
            end
        end
        bus.in_valid = 1'b0;
        if (!got) begin
            tmo_cnt++;
            start = 1'b0;
        end else begin
            start = chain;
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    function automatic logic [DW-1:0] rnd_val();
        case ($urandom_range(0, 4))
            0:       return $urandom;
            1:       return DW'($urandom_range(0, 7));
            2:       return 32'h8000_0000 | $urandom;
            3:       return 32'h7FFF_FFFF & $urandom;
            default: return DW'($urandom_range(0, 32'h0004_0000));
        endcase
    endfunction

    initial begin
        logic [DW-1:0] v [N];
        bit chained;
        bit nxt;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        v = '{32'h0001_0000, 32'hFFFE_0000, 32'h0003_0000, 32'h0000_0000};
        pin_lit = '{32'h0001_0000, 32'h0, 32'h0003_0000, 32'h0};
        pin_en = 1'b1;
        run_layer(v, 0, 1'b0, 1'b0, 1'b0);

        v = '{32'h0002_0000, 32'h0002_0000, 32'h0002_0000, 32'h0002_0000};
        pin_lit = '{32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
        run_layer(v, 0, 1'b0, 1'b0, 1'b0);

        v = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        pin_lit = '{32'h0, 32'h0, 32'h0, 32'h0};
        run_layer(v, 0, 1'b0, 1'b0, 1'b0);

        v = '{32'h7FFF_FFFF, 32'h0, 32'h0, 32'h0};
        pin_lit = '{32'h0004_0000, 32'h0, 32'h0, 32'h0};
        run_layer(v, 0, 1'b0, 1'b0, 1'b0);

        v = '{32'h0000_0001, 32'h0, 32'h0, 32'h0};
        pin_lit = '{32'h0001_0000, 32'h0, 32'h0, 32'h0};
        run_layer(v, 0, 1'b0, 1'b0, 1'b0);

        // Stalled stream with start held through the whole pass.
        v = '{32'h0001_0000, 32'hFFFE_0000, 32'h0003_0000, 32'h0000_0000};
        pin_lit = '{32'h0001_0000, 32'h0, 32'h0003_0000, 32'h0};
        run_layer(v, 60, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of neuron 2's division.
        pin_en = 1'b0;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < N; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = rnd_val();
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        repeat (120) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #2 rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;

        v = '{32'h0001_0000, 32'hFFFE_0000, 32'h0003_0000, 32'h0000_0000};
        pin_lit = '{32'h0001_0000, 32'h0, 32'h0003_0000, 32'h0};
        pin_en = 1'b1;
        run_layer(v, 0, 1'b0, 1'b0, 1'b0);

        pin_en = 1'b0;
        chained = 1'b0;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) v[i] = rnd_val();
            nxt = (r < 7) && (($urandom_range(0, 1)) == 1);
            run_layer(v, int'($urandom_range(0, 60)), 1'($urandom_range(0, 1)), nxt, chained);
            chained = nxt;
        end

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
